pipe_reg_chain: RTL
===================

# pipe_reg_chain

Parametrised inter-stage register chain that carries one field (IR, PC, control word, …) down the pipeline, one register per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB for the default depth). It generalises the fixed, always-loading four-register shift chain: width, depth and bubble value are parameters. Each stage has its own valid bit, per-stage stall with automatic back-propagation and bubble insertion, and per-stage flush. The datapath instantiates one chain per carried field, all driven from the same hazard unit.

## Interface
- WIDTH, 32, bits per stage register
- STAGES, 4, number of stage registers; index 0 = youngest (IF/ID), STAGES-1 = oldest (MEM/WB); legal range 1..8
- BUBBLE_VAL, 0, data value loaded on reset, flush and bubble insertion (IR chain uses pipeline_pkg::NOP_INSN)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in  in  WIDTH  data presented to stage 0
- in_valid  in  1  `in` carries a real entry
- in_ready  out  1  stage 0 will capture `in` this edge (= ~hold[0])
- stall  in  STAGES  stall[i] requests stage i hold its contents
- flush  in  STAGES  flush[i] forces stage i to a bubble at the next edge
- data  out  STAGES*WIDTH  flat stage contents; stage i at [i*WIDTH +: WIDTH]
- valid  out  STAGES  per-stage valid bit
- occupancy  out  $clog2(STAGES+1)  combinational popcount of `valid`

## Operation
- Effective hold: hold[i] = OR of stall[j] for j >= i. A stalled older stage freezes every younger stage; callers never need to assert consistent vectors.
- Per-stage next state, priority high→low:
  - reset: data = BUBBLE_VAL, valid = 0 (all stages).
  - flush[i]: data = BUBBLE_VAL, valid = 0; overrides hold and any entry arriving from stage i-1.
  - hold[i]: keep data and valid.
  - i > 0 and hold[i-1]: bubble inserted (data = BUBBLE_VAL, valid = 0); the held entry must not be duplicated.
  - otherwise advance: stage 0 takes in/in_valid (in_valid = 0 loads a bubble); stage i > 0 takes stage i-1.
- A bubble entering with valid = 0 always carries data = BUBBLE_VAL, never stale data.
- Stage STAGES-1 entries leave the chain when the stage is not held; no backpressure beyond stall[STAGES-1].
- in_ready depends only on stall (combinational); it is independent of flush. When flush[0] is asserted with in_ready = 1, `in` is dropped.
- STAGES = 1: chain is a single register; the bubble-insertion rule does not apply.

## Timing
- Latency: an entry accepted at edge n is visible in stage k after edge n+k, provided no hold occurs in between.
- Each held cycle adds exactly one cycle of latency to every entry at or younger than the highest stalled stage.
- Outputs `data`/`valid` are registered; `in_ready` and `occupancy` are combinational.
- After reset deasserts, first capture occurs at the next edge; reset asserted mid-stream clears all stages at that edge regardless of stall/flush.
- Simultaneous stall[i] and flush[i]: stage i becomes a bubble; stages < i still hold.

## Structure
- pipeline_pkg holds NOP_INSN (32'h00000013), the stage index constants (STG_IF_ID … STG_MEM_WB), and the control-word struct type used by the CW chain.
- One natural sub-module: pipe_stage_reg (one data+valid register with load/flush/bubble controls), generated STAGES times; hold-vector and popcount logic stay in pipe_reg_chain.

## Test plan
- Reset, then in = 0xA0, 0xA1, 0xA2, 0xA3 with in_valid = 1 on consecutive cycles -> stage 3 shows 0xA0 with valid = 1 on the 4th edge; occupancy = 4.
- Full pipe, stall[1] = 1 for 2 cycles -> stages 0–1 frozen, stage 2 gets a bubble with BUBBLE_VAL and valid = 0 for each stalled cycle, in_ready = 0; resuming shows no duplicated or lost entry.
- stall = 4'b0100 only -> stages 0–2 hold (hold back-propagation), stage 3 gets a bubble.
- Full pipe, flush = 4'b0011 with stall = 0 -> next edge stages 0–1 are bubbles, stage 2 holds the old stage-1 entry, occupancy = 2.
- stall[2] and flush[2] together -> stage 2 becomes a bubble, stages 0–1 hold, stage 3 bubble.
- reset asserted during a stall with STAGES = 8, WIDTH = 64, BUBBLE_VAL = 64'h13 -> every stage = 0x13 with valid = 0 after one edge; occupancy = 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline constants, stage indices and control-word type.
package pipeline_pkg;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WB = 3;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    logic [3:0] alu_op;
    wb_sel_e wb_sel;
  } cw_t;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one data+valid stage register with flush, hold and bubble controls.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  always_comb begin
    data_d  = flush ? BUBBLE_VAL : hold ? data_q  : bubble ? BUBBLE_VAL : d_in;
    valid_d = flush ? 1'b0       : hold ? valid_q : bubble ? 1'b0       : v_in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= BUBBLE_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign d_out = data_q;
  assign v_out = valid_q;
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parametrised inter-stage register chain with per-stage valid, stall and flush.
module pipe_reg_chain
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 4,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  output logic [STAGES*WIDTH-1:0]      data,
  output logic [STAGES-1:0]            valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);
  localparam int OCC_W = $clog2(STAGES+1);
  logic [STAGES-1:0] hold;
  // A stall anywhere downstream freezes every younger stage.
  always_comb begin
    hold = stall;
    for (int i = STAGES-2; i >= 0; i--) hold[i] = stall[i] | hold[i+1];
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCC_W'(valid[i]);
  end
  assign in_ready = ~hold[0];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      pipe_stage_reg #(.WIDTH(WIDTH), .BUBBLE_VAL(BUBBLE_VAL)) u_reg (
        .clk(clk), .reset(reset), .flush(flush[0]), .hold(hold[0]), .bubble(1'b0),
        .d_in(in_valid ? in : BUBBLE_VAL), .v_in(in_valid),
        .d_out(data[0 +: WIDTH]), .v_out(valid[0])
      );
    end else begin : g_body
      pipe_stage_reg #(.WIDTH(WIDTH), .BUBBLE_VAL(BUBBLE_VAL)) u_reg (
        .clk(clk), .reset(reset), .flush(flush[s]), .hold(hold[s]), .bubble(hold[s-1]),
        .d_in(data[(s-1)*WIDTH +: WIDTH]), .v_in(valid[s-1]),
        .d_out(data[s*WIDTH +: WIDTH]), .v_out(valid[s])
      );
    end
  end
endmodule
